dpram_arbiter: RTL and testbench

Two-client arbiter and sequencer for the 256x16 dual-port RAM (one write port, one registered read port). Clients A and B each get an independent write-request channel and read-request channel with valid/ready handshakes. Write and read ports are arbitrated separately, round-robin. Read data is routed back to the issuing client with fixed latency. The block sits directly in front of the RAM; the RAM has no other masters.

---
 rtl/dpram_arb_pkg.sv | 6 +
 rtl/dpram_arbiter_if.sv | 30 +++
 rtl/rr_arb2.sv | 16 +
 rtl/dpram_arbiter.sv | 45 ++++
 tb/tb_dpram_arbiter.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/dpram_arb_pkg.sv
// dpram_arb_pkg: client identifiers and default geometry for the dual-port RAM arbiter
package dpram_arb_pkg;
   typedef enum logic {CLIENT_A = 1'b0, CLIENT_B = 1'b1} client_id_t;
   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 16;
endpackage

// File: rtl/dpram_arbiter_if.sv
// dpram_arbiter_if: client write/read channels plus the RAM-facing port of the arbiter
interface dpram_arbiter_if import dpram_arb_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();
   logic              a_wvalid, b_wvalid, a_wready, b_wready;
   logic [ADDR_W-1:0] a_waddr, b_waddr;
   logic [DATA_W-1:0] a_wdata, b_wdata;
   logic              a_rvalid, b_rvalid, a_rready, b_rready;
   logic [ADDR_W-1:0] a_raddr, b_raddr;
   logic              a_rresp_valid, b_rresp_valid;
   logic [DATA_W-1:0] a_rresp_data, b_rresp_data;
   logic              ram_wr;
   logic [ADDR_W-1:0] ram_w_addr, ram_r_addr;
   logic [DATA_W-1:0] ram_din, ram_dout;
   modport slave (
      input  a_wvalid, b_wvalid, a_waddr, b_waddr, a_wdata, b_wdata,
      input  a_rvalid, b_rvalid, a_raddr, b_raddr, ram_dout,
      output a_wready, b_wready, a_rready, b_rready,
      output a_rresp_valid, b_rresp_valid, a_rresp_data, b_rresp_data,
      output ram_wr, ram_w_addr, ram_din, ram_r_addr
   );
   modport master (
      output a_wvalid, b_wvalid, a_waddr, b_waddr, a_wdata, b_wdata,
      output a_rvalid, b_rvalid, a_raddr, b_raddr, ram_dout,
      input  a_wready, b_wready, a_rready, b_rready,
      input  a_rresp_valid, b_rresp_valid, a_rresp_data, b_rresp_data,
      input  ram_wr, ram_w_addr, ram_din, ram_r_addr
   );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; pointer names the client that wins a tie
module rr_arb2 import dpram_arb_pkg::*; (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic [1:0] grant_o
);
   client_id_t ptr_q, ptr_d;
   always_comb begin
      grant_o = rst ? 2'b00 : &req_i ? (ptr_q == CLIENT_B ? 2'b10 : 2'b01) : req_i;
      ptr_d = ptr_q;
      if (advance_i && |grant_o) ptr_d = grant_o[1] ? CLIENT_A : CLIENT_B;
   end
   always_ff @(posedge clk) ptr_q <= rst ? CLIENT_A : ptr_d;
endmodule

// File: rtl/dpram_arbiter.sv
// dpram_arbiter: round-robin write/read arbitration for a 1W/1R registered RAM,
// routing each read response back to its issuing client one cycle later
module dpram_arbiter import dpram_arb_pkg::*; #(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter bit RAW_STALL = 1'b1
) (
   input logic             clk,
   input logic             rst,
   dpram_arbiter_if.slave  bus
);
   logic [1:0]        wgnt, rgnt;
   logic              raw, rxfer, pend_v_q, pend_v_d;
   client_id_t        pend_id_q, pend_id_d;
   logic [ADDR_W-1:0] rsel, raddr_q;
   logic [DATA_W-1:0] wsel;
   rr_arb2 u_warb (.clk, .rst, .req_i({bus.b_wvalid, bus.a_wvalid}), .advance_i(1'b1), .grant_o(wgnt));
   rr_arb2 u_rarb (.clk, .rst, .req_i({bus.b_rvalid, bus.a_rvalid}), .advance_i(!raw), .grant_o(rgnt));
   always_comb begin
      wsel = wgnt[1] ? bus.b_wdata : bus.a_wdata;
      bus.a_wready = wgnt[0];
      bus.b_wready = wgnt[1];
      bus.ram_wr = |wgnt;
      bus.ram_w_addr = wgnt[1] ? bus.b_waddr : bus.a_waddr;
      bus.ram_din = wsel;
      rsel = rgnt[1] ? bus.b_raddr : bus.a_raddr;
      // holding the read one cycle lets it observe the write landing this cycle
      raw = RAW_STALL && |rgnt && bus.ram_wr && rsel == bus.ram_w_addr;
      rxfer = |rgnt && !raw;
      bus.a_rready = rgnt[0] && !raw;
      bus.b_rready = rgnt[1] && !raw;
      bus.ram_r_addr = rxfer ? rsel : raddr_q;
      pend_v_d = !rst && rxfer;
      pend_id_d = rgnt[1] ? CLIENT_B : CLIENT_A;
      bus.a_rresp_valid = !rst && pend_v_q && pend_id_q == CLIENT_A;
      bus.b_rresp_valid = !rst && pend_v_q && pend_id_q == CLIENT_B;
      bus.a_rresp_data = bus.ram_dout;
      bus.b_rresp_data = bus.ram_dout;
   end
   always_ff @(posedge clk) begin
      pend_v_q <= pend_v_d;
      pend_id_q <= pend_id_d;
      raddr_q <= rst ? '0 : bus.ram_r_addr;
   end
endmodule

// File: tb/tb_dpram_arbiter.sv
// tb_dpram_arbiter: drives one stall and one no-stall arbiter, each with its own RAM,
// against a per-cycle reference model of grants, RAM contents and responses
module tb_dpram_arbiter;
   logic clk = 1'b0, rst = 1'b1;
   logic a_wvalid = 1'b0, b_wvalid = 1'b0, a_rvalid = 1'b0, b_rvalid = 1'b0;
   logic [7:0] a_waddr = '0, b_waddr = '0, a_raddr = '0, b_raddr = '0;
   logic [15:0] a_wdata = '0, b_wdata = '0;
   logic [6:0] flg[2];
   logic [7:0] wa[2], ra[2];
   logic [15:0] wd[2], rda[2], rdb[2], dout[2];
   logic [15:0] ram[2][256];
   logic [15:0] mm[2][256];
   logic [15:0] pd[2];
   int wp[2], rp[2], pv[2], pid[2], ew[2], er[2];
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 2; g++) begin : u
      dpram_arbiter_if ifc ();
      dpram_arbiter #(.RAW_STALL(g == 1)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));
      assign ifc.a_wvalid = a_wvalid;
      assign ifc.b_wvalid = b_wvalid;
      assign ifc.a_waddr = a_waddr;
      assign ifc.b_waddr = b_waddr;
      assign ifc.a_wdata = a_wdata;
      assign ifc.b_wdata = b_wdata;
      assign ifc.a_rvalid = a_rvalid;
      assign ifc.b_rvalid = b_rvalid;
      assign ifc.a_raddr = a_raddr;
      assign ifc.b_raddr = b_raddr;
      assign ifc.ram_dout = dout[g];
      assign flg[g] = {ifc.a_wready, ifc.b_wready, ifc.a_rready, ifc.b_rready,
                       ifc.ram_wr, ifc.a_rresp_valid, ifc.b_rresp_valid};
      assign wa[g] = ifc.ram_w_addr;
      assign wd[g] = ifc.ram_din;
      assign ra[g] = ifc.ram_r_addr;
      assign rda[g] = ifc.a_rresp_data;
      assign rdb[g] = ifc.b_rresp_data;
   end
   // behavioural 1W/1R RAM with registered read and old-data on collision
   always @(posedge clk)
      for (int k = 0; k < 2; k++)
         if (rst) begin
            for (int j = 0; j < 256; j++) ram[k][j] <= '0;
            dout[k] <= '0;
         end else begin
            if (flg[k][2]) ram[k][wa[k]] <= wd[k];
            dout[k] <= ram[k][ra[k]];
         end
   function automatic int arb(logic a, logic b, int p);
      return (a && b) ? p : a ? 0 : b ? 1 : -1;
   endfunction
   task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s raw_stall=%0d observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask
   task automatic cyc();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         int w, r;
         logic [7:0] wad, rad;
         w = rst ? -1 : arb(a_wvalid, b_wvalid, wp[k]);
         r = rst ? -1 : arb(a_rvalid, b_rvalid, rp[k]);
         wad = w == 1 ? b_waddr : a_waddr;
         rad = r == 1 ? b_raddr : a_raddr;
         if (k == 1 && w >= 0 && r >= 0 && rad == wad) r = -1;
         ew[k] = w;
         er[k] = r;
         chk("a_wready", k, 32'(flg[k][6]), 32'(w == 0));
         chk("b_wready", k, 32'(flg[k][5]), 32'(w == 1));
         chk("a_rready", k, 32'(flg[k][4]), 32'(r == 0));
         chk("b_rready", k, 32'(flg[k][3]), 32'(r == 1));
         chk("ram_wr", k, 32'(flg[k][2]), 32'(w >= 0));
         if (w >= 0) begin
            chk("ram_w_addr", k, 32'(wa[k]), 32'(wad));
            chk("ram_din", k, 32'(wd[k]), 32'(w == 1 ? b_wdata : a_wdata));
         end
         if (r >= 0) chk("ram_r_addr", k, 32'(ra[k]), 32'(rad));
         chk("a_rresp_valid", k, 32'(flg[k][1]), 32'(!rst && pv[k] != 0 && pid[k] == 0));
         chk("b_rresp_valid", k, 32'(flg[k][0]), 32'(!rst && pv[k] != 0 && pid[k] == 1));
         if (!rst && pv[k] != 0) chk("rresp_data", k, 32'(pid[k] == 1 ? rdb[k] : rda[k]), 32'(pd[k]));
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++)
         if (rst) begin
            for (int j = 0; j < 256; j++) mm[k][j] = '0;
            wp[k] = 0;
            rp[k] = 0;
            pv[k] = 0;
         end else begin
            pv[k] = int'(er[k] >= 0);
            pid[k] = er[k];
            if (er[k] >= 0) begin
               pd[k] = mm[k][er[k] == 1 ? b_raddr : a_raddr];
               rp[k] = 1 - er[k];
            end
            if (ew[k] >= 0) begin
               mm[k][ew[k] == 1 ? b_waddr : a_waddr] = ew[k] == 1 ? b_wdata : a_wdata;
               wp[k] = 1 - ew[k];
            end
         end
      #1;
   endtask
   initial begin
      a_wvalid = 1'b1; b_wvalid = 1'b1; a_rvalid = 1'b1; b_rvalid = 1'b1;
      a_waddr = 8'h10; a_wdata = 16'hAAAA; b_waddr = 8'h20; b_wdata = 16'hBBBB;
      a_raddr = 8'h44; b_raddr = 8'h45;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
      a_rvalid = 1'b0;
      cyc();
      b_rvalid = 1'b0;
      repeat (3) cyc();
      a_wvalid = 1'b0; b_wvalid = 1'b0;
      a_raddr = 8'h10; b_raddr = 8'h20;
      a_rvalid = 1'b1; b_rvalid = 1'b1;
      cyc();
      a_rvalid = 1'b0;
      cyc();
      b_rvalid = 1'b0;
      cyc();
      cyc();
      a_rvalid = 1'b1; a_raddr = 8'h33;
      b_wvalid = 1'b1; b_waddr = 8'h33; b_wdata = 16'h5A5A;
      cyc();
      b_wvalid = 1'b0;
      cyc();
      a_rvalid = 1'b0;
      cyc();
      cyc();
      a_rvalid = 1'b1; a_raddr = 8'h10;
      cyc();
      a_rvalid = 1'b0; rst = 1'b1;
      cyc();
      rst = 1'b0; a_rvalid = 1'b1; a_raddr = 8'h20;
      cyc();
      a_rvalid = 1'b0;
      cyc();
      cyc();
      for (int i = 0; i < 400; i++) begin
         rst = $urandom_range(63) == 0;
         a_wvalid = 1'($urandom_range(1));
         b_wvalid = 1'($urandom_range(1));
         a_rvalid = 1'($urandom_range(1));
         b_rvalid = 1'($urandom_range(1));
         a_waddr = 8'h30 + 8'($urandom_range(3));
         b_waddr = 8'h30 + 8'($urandom_range(3));
         a_raddr = 8'h30 + 8'($urandom_range(3));
         b_raddr = 8'h30 + 8'($urandom_range(3));
         a_wdata = 16'($urandom);
         b_wdata = 16'($urandom);
         cyc();
      end
      rst = 1'b0;
      a_wvalid = 1'b0; b_wvalid = 1'b0; a_rvalid = 1'b0; b_rvalid = 1'b0;
      cyc();
      cyc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
